instruction_fetch_rvc: RTL and testbench

//  IF stage of the RV32I+C pipeline; directly upstream of instruction_decode. Fetches aligned
//  32-bit words from the I-cache and realigns 16/32-bit instructions across word boundaries

---
 rtl/instruction_fetch_rvc.sv | 217 +++++++++++++++++++++
 tb/tb_instruction_fetch_rvc.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_rvc.sv
// RV32IC fetch stage: realigns 16/32-bit ops from aligned I-cache words through a
// one-halfword buffer, expands RVC to 32-bit and applies static branch redirection.
module instruction_fetch_rvc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memory_stall,
  input  logic        hazard_stall,
  input  logic        flush,
  input  logic [31:0] flush_PC,
  output logic        ICACHE_ren,
  output logic [29:0] ICACHE_addr,
  input  logic [31:0] ICACHE_rdata,
  output logic [31:0] bp_PC,
  input  logic        bp_taken,
  output logic [31:0] instruction_1,
  output logic [31:0] PC_1,
  output logic        prev_taken_1,
  output logic        compressed_1
);

  logic [31:0] pc_q, pc_d;
  logic [29:0] fetch_addr_q, fetch_addr_d;
  logic [15:0] hbuf_q, hbuf_d;
  logic        hbuf_v_q, hbuf_v_d;
  logic [31:0] inst_q, inst_d, pc1_q, pc1_d;
  logic        taken1_q, taken1_d, comp1_q, comp1_d;

  logic [31:0] iss_inst, br_imm, target;
  logic        iss_valid, iss_comp, iss_consume, predict;
  logic [2:0]  iss_step;
  logic [15:0] iss_hbuf;
  logic        iss_hbuf_v;

  function automatic logic [31:0] rvc_expand(input logic [15:0] c);
    logic [4:0]  rd, rs2, rdp, rs1p;
    logic [11:0] imm6, lw_off, lwsp_off, swsp_off;
    logic [20:0] j_off;
    logic [12:0] b_off;
    logic [31:0] r;
    rd       = c[11:7];
    rs2      = c[6:2];
    rdp      = {2'b01, c[4:2]};
    rs1p     = {2'b01, c[9:7]};
    imm6     = {{7{c[12]}}, c[6:2]};
    lw_off   = {5'b0, c[5], c[12:10], c[6], 2'b00};
    lwsp_off = {4'b0, c[3:2], c[12], c[6:4], 2'b00};
    swsp_off = {4'b0, c[8:7], c[12:9], 2'b00};
    j_off    = {{10{c[12]}}, c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
    b_off    = {{5{c[12]}}, c[6:5], c[2], c[11:10], c[4:3], 1'b0};
    r        = NOP_INST;
    case ({c[1:0], c[15:13]})
      5'b00_010: r = {lw_off, rs1p, 3'b010, rdp, 7'b0000011};
      5'b00_110: r = {lw_off[11:5], rdp, rs1p, 3'b010, lw_off[4:0], 7'b0100011};
      5'b01_000: r = {imm6, rd, 3'b000, rd, 7'b0010011};
      5'b01_001: r = {j_off[20], j_off[10:1], j_off[11], j_off[19:12], 5'd1, 7'b1101111};
      5'b01_010: r = {imm6, 5'd0, 3'b000, rd, 7'b0010011};
      5'b01_100: begin
        case (c[11:10])
          2'b00: if (!c[12]) r = {7'b0000000, c[6:2], rs1p, 3'b101, rs1p, 7'b0010011};
          2'b01: if (!c[12]) r = {7'b0100000, c[6:2], rs1p, 3'b101, rs1p, 7'b0010011};
          2'b10: r = {imm6, rs1p, 3'b111, rs1p, 7'b0010011};
          default: begin
            if (!c[12]) begin
              case (c[6:5])
                2'b00:   r = {7'b0100000, rdp, rs1p, 3'b000, rs1p, 7'b0110011};
                2'b01:   r = {7'b0000000, rdp, rs1p, 3'b100, rs1p, 7'b0110011};
                2'b10:   r = {7'b0000000, rdp, rs1p, 3'b110, rs1p, 7'b0110011};
                default: r = {7'b0000000, rdp, rs1p, 3'b111, rs1p, 7'b0110011};
              endcase
            end
          end
        endcase
      end
      5'b01_101: r = {j_off[20], j_off[10:1], j_off[11], j_off[19:12], 5'd0, 7'b1101111};
      5'b01_110: r = {b_off[12], b_off[10:5], 5'd0, rs1p, 3'b000, b_off[4:1], b_off[11], 7'b1100011};
      5'b01_111: r = {b_off[12], b_off[10:5], 5'd0, rs1p, 3'b001, b_off[4:1], b_off[11], 7'b1100011};
      5'b10_000: if (!c[12]) r = {7'b0000000, c[6:2], rd, 3'b001, rd, 7'b0010011};
      5'b10_010: if (rd != 5'd0) r = {lwsp_off, 5'd2, 3'b010, rd, 7'b0000011};
      5'b10_100: begin
        if (rs2 == 5'd0) begin
          // rs1 == x0 encodes reserved / EBREAK, neither of which is expanded
          if (rd != 5'd0) r = {12'b0, rd, 3'b000, 4'b0, c[12], 7'b1100111};
        end else if (!c[12]) begin
          r = {7'b0000000, rs2, 5'd0, 3'b000, rd, 7'b0110011};
        end else begin
          r = {7'b0000000, rs2, rd, 3'b000, rd, 7'b0110011};
        end
      end
      5'b10_110: r = {swsp_off[11:5], rs2, 5'd2, 3'b010, swsp_off[4:0], 7'b0100011};
      default:   r = NOP_INST;
    endcase
    return r;
  endfunction

  // Select the op issued this cycle from the halfword buffer and the fetched word
  always_comb begin
    iss_inst    = NOP_INST;
    iss_valid   = 1'b1;
    iss_comp    = 1'b0;
    iss_step    = 3'd0;
    iss_consume = 1'b1;
    iss_hbuf    = hbuf_q;
    iss_hbuf_v  = 1'b0;
    if (!hbuf_v_q) begin
      if (!pc_q[1]) begin
        if (ICACHE_rdata[1:0] != 2'b11) begin
          iss_inst   = rvc_expand(ICACHE_rdata[15:0]);
          iss_comp   = 1'b1;
          iss_step   = 3'd2;
          iss_hbuf   = ICACHE_rdata[31:16];
          iss_hbuf_v = 1'b1;
        end else begin
          iss_inst = ICACHE_rdata;
          iss_step = 3'd4;
        end
      end else if (ICACHE_rdata[17:16] != 2'b11) begin
        iss_inst = rvc_expand(ICACHE_rdata[31:16]);
        iss_comp = 1'b1;
        iss_step = 3'd2;
      end else begin
        iss_valid  = 1'b0;
        iss_hbuf   = ICACHE_rdata[31:16];
        iss_hbuf_v = 1'b1;
      end
    end else if (hbuf_q[1:0] != 2'b11) begin
      iss_inst    = rvc_expand(hbuf_q);
      iss_comp    = 1'b1;
      iss_step    = 3'd2;
      iss_consume = 1'b0;
    end else begin
      iss_inst   = {ICACHE_rdata[15:0], hbuf_q};
      iss_step   = 3'd4;
      iss_hbuf   = ICACHE_rdata[31:16];
      iss_hbuf_v = 1'b1;
    end
  end

  always_comb begin
    br_imm = (iss_inst[6:0] == 7'b1100011)
           ? {{20{iss_inst[31]}}, iss_inst[7], iss_inst[30:25], iss_inst[11:8], 1'b0}
           : {{12{iss_inst[31]}}, iss_inst[19:12], iss_inst[20], iss_inst[30:21], 1'b0};
    target  = pc_q + br_imm;
    predict = iss_valid && bp_taken &&
              ((iss_inst[6:0] == 7'b1100011) || (iss_inst[6:0] == 7'b1101111));
  end

  always_comb begin
    pc_d         = pc_q;
    fetch_addr_d = fetch_addr_q;
    hbuf_d       = hbuf_q;
    hbuf_v_d     = hbuf_v_q;
    inst_d       = inst_q;
    pc1_d        = pc1_q;
    taken1_d     = taken1_q;
    comp1_d      = comp1_q;
    if (memory_stall) begin
      // hold everything; EX keeps flush high until the stall drops
    end else if (flush) begin
      pc_d         = flush_PC;
      fetch_addr_d = flush_PC[31:2];
      hbuf_v_d     = 1'b0;
      inst_d       = NOP_INST;
      pc1_d        = '0;
      taken1_d     = 1'b0;
      comp1_d      = 1'b0;
    end else if (!hazard_stall) begin
      inst_d   = iss_inst;
      pc1_d    = pc_q;
      comp1_d  = iss_comp;
      taken1_d = predict;
      if (predict) begin
        pc_d         = target;
        fetch_addr_d = target[31:2];
        hbuf_v_d     = 1'b0;
      end else begin
        pc_d         = pc_q + {29'b0, iss_step};
        fetch_addr_d = fetch_addr_q + {29'b0, iss_consume};
        hbuf_d       = iss_hbuf;
        hbuf_v_d     = iss_hbuf_v;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      fetch_addr_q <= RESET_PC[31:2];
      hbuf_q       <= '0;
      hbuf_v_q     <= 1'b0;
      inst_q       <= NOP_INST;
      pc1_q        <= '0;
      taken1_q     <= 1'b0;
      comp1_q      <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      fetch_addr_q <= fetch_addr_d;
      hbuf_q       <= hbuf_d;
      hbuf_v_q     <= hbuf_v_d;
      inst_q       <= inst_d;
      pc1_q        <= pc1_d;
      taken1_q     <= taken1_d;
      comp1_q      <= comp1_d;
    end
  end

  assign ICACHE_ren    = 1'b1;
  assign ICACHE_addr   = fetch_addr_q;
  assign bp_PC         = pc_q;
  assign instruction_1 = inst_q;
  assign PC_1          = pc1_q;
  assign prev_taken_1  = taken1_q;
  assign compressed_1  = comp1_q;

endmodule

// File: tb/tb_instruction_fetch_rvc.sv
// Directed bench for instruction_fetch_rvc: combinational word memory, static predictor
// stub that answers "taken" for one chosen PC, hand-computed expected outputs.
module tb_instruction_fetch_rvc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        memory_stall = 1'b0;
  logic        hazard_stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_PC = '0;
  logic        ICACHE_ren;
  logic [29:0] ICACHE_addr;
  logic [31:0] ICACHE_rdata;
  logic [31:0] bp_PC;
  logic        bp_taken;
  logic [31:0] instruction_1;
  logic [31:0] PC_1;
  logic        prev_taken_1;
  logic        compressed_1;

  logic [31:0] mem [0:127];
  logic        take_en = 1'b0;
  logic [31:0] take_pc = '0;
  int          checks = 0;
  int          errors = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  instruction_fetch_rvc #(.RESET_PC(32'h0), .NOP_INST(32'h0000_0013)) dut (
    .clk(clk), .rst_n(rst_n), .memory_stall(memory_stall), .hazard_stall(hazard_stall),
    .flush(flush), .flush_PC(flush_PC), .ICACHE_ren(ICACHE_ren), .ICACHE_addr(ICACHE_addr),
    .ICACHE_rdata(ICACHE_rdata), .bp_PC(bp_PC), .bp_taken(bp_taken),
    .instruction_1(instruction_1), .PC_1(PC_1), .prev_taken_1(prev_taken_1),
    .compressed_1(compressed_1)
  );

  always #5 clk = ~clk;

  assign ICACHE_rdata = memory_stall ? 32'hDEAD_BEEF : mem[ICACHE_addr[6:0]];
  assign bp_taken     = take_en && (bp_PC == take_pc);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                         input logic comp, input logic taken);
    chk({tag, ".inst"}, instruction_1, inst);
    chk({tag, ".pc"}, PC_1, pc);
    chk({tag, ".comp"}, {31'b0, compressed_1}, {31'b0, comp});
    chk({tag, ".taken"}, {31'b0, prev_taken_1}, {31'b0, taken});
  endtask

  task automatic do_flush(input string tag, input logic [31:0] pc);
    flush    = 1'b1;
    flush_PC = pc;
    tick();
    flush = 1'b0;
    chk_out(tag, NOP, 32'h0, 1'b0, 1'b0);
    chk({tag, ".addr"}, {2'b0, ICACHE_addr}, {2'b0, pc[31:2]});
    chk({tag, ".bp_pc"}, bp_PC, pc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_tab [0:7];
    for (int i = 0; i < 128; i++) mem[i] = NOP;
    mem[8'h00] = 32'h00A0_0093;
    mem[8'h01] = 32'h0010_8113;
    mem[8'h08] = 32'h0000_0863;
    mem[8'h0C] = 32'h0010_8113;
    mem[8'h10] = 32'h0085_4505;
    mem[8'h18] = 32'h0000_C401;
    mem[8'h20] = 32'h0093_4505;
    mem[8'h21] = 32'h4505_00A0;
    mem[8'h30] = 32'h4144_852E;
    mem[8'h31] = 32'h848D_8C05;
    mem[8'h32] = 32'h8082_117D;
    mem[8'h33] = 32'h4092_C42A;
    mem[8'h40] = 32'h0085_4505;
    exp_tab[0] = 32'h00B0_0533;  // c.mv   x10,x11
    exp_tab[1] = 32'h0045_2483;  // c.lw   x9,4(x10)
    exp_tab[2] = 32'h4094_0433;  // c.sub  x8,x9
    exp_tab[3] = 32'h4034_D493;  // c.srai x9,3
    exp_tab[4] = 32'hFFF1_0113;  // c.addi x2,-1
    exp_tab[5] = 32'h0000_8067;  // c.jr   x1
    exp_tab[6] = 32'h00A1_2423;  // c.swsp x10,8(sp)
    exp_tab[7] = 32'h0041_2083;  // c.lwsp x1,4(sp)

    // reset state
    tick();
    tick();
    chk_out("reset", NOP, 32'h0, 1'b0, 1'b0);
    chk("reset.addr", {2'b0, ICACHE_addr}, 32'h0);
    chk("reset.bp_pc", bp_PC, 32'h0);
    rst_n = 1'b1;
    chk("ren", {31'b0, ICACHE_ren}, 32'h1);

    // two aligned 32-bit words, one per cycle
    tick();
    chk_out("w0", 32'h00A0_0093, 32'h0, 1'b0, 1'b0);
    chk("w0.addr", {2'b0, ICACHE_addr}, 32'h1);
    tick();
    chk_out("w1", 32'h0010_8113, 32'h4, 1'b0, 1'b0);

    // two compressed ops in one word; address held while the buffered half issues
    do_flush("fl40", 32'h40);
    tick();
    chk_out("caseA", 32'h0010_0513, 32'h40, 1'b1, 1'b0);
    chk("caseA.addr", {2'b0, ICACHE_addr}, 32'h11);
    tick();
    chk_out("caseD", 32'h0010_8093, 32'h42, 1'b1, 1'b0);
    chk("caseD.addr", {2'b0, ICACHE_addr}, 32'h11);
    chk("caseD.bp_pc", bp_PC, 32'h44);
    tick();
    chk_out("after_D", NOP, 32'h44, 1'b0, 1'b0);

    // 32-bit op spanning a word boundary
    do_flush("fl80", 32'h80);
    tick();
    chk_out("span.A", 32'h0010_0513, 32'h80, 1'b1, 1'b0);
    tick();
    chk_out("span.E", 32'h00A0_0093, 32'h82, 1'b0, 1'b0);
    chk("span.addr", {2'b0, ICACHE_addr}, 32'h22);
    tick();
    chk_out("span.D", 32'h0010_0513, 32'h86, 1'b1, 1'b0);

    // flush to an odd halfword with a stale 32-bit half in the buffer
    do_flush("fl80b", 32'h80);
    tick();
    chk_out("pre.A", 32'h0010_0513, 32'h80, 1'b1, 1'b0);
    do_flush("fl102", 32'h102);
    tick();
    chk_out("caseC", 32'h0010_8093, 32'h102, 1'b1, 1'b0);
    chk("caseC.addr", {2'b0, ICACHE_addr}, 32'h41);
    tick();
    chk_out("after_C", NOP, 32'h104, 1'b0, 1'b0);

    // odd-halfword entry on a 32-bit op: bubble, then spanning issue at same PC
    do_flush("fl82", 32'h82);
    tick();
    chk_out("C32.bubble", NOP, 32'h82, 1'b0, 1'b0);
    chk("C32.bp_pc", bp_PC, 32'h82);
    chk("C32.addr", {2'b0, ICACHE_addr}, 32'h21);
    tick();
    chk_out("C32.E", 32'h00A0_0093, 32'h82, 1'b0, 1'b0);
    tick();
    chk_out("C32.D", 32'h0010_0513, 32'h86, 1'b1, 1'b0);

    // 16'h0000 is illegal RVC
    do_flush("fl62", 32'h62);
    tick();
    chk_out("illegal", NOP, 32'h62, 1'b1, 1'b0);

    // predicted-taken beq +16
    take_en = 1'b1;
    take_pc = 32'h20;
    do_flush("fl20", 32'h20);
    tick();
    chk_out("beq.t", 32'h0000_0863, 32'h20, 1'b0, 1'b1);
    chk("beq.addr", {2'b0, ICACHE_addr}, 32'hC);
    chk("beq.bp_pc", bp_PC, 32'h30);
    tick();
    chk_out("beq.tgt", 32'h0010_8113, 32'h30, 1'b0, 1'b0);

    // same beq not predicted, then taken hint on a non-branch is ignored
    take_en = 1'b0;
    do_flush("fl20b", 32'h20);
    tick();
    chk_out("beq.nt", 32'h0000_0863, 32'h20, 1'b0, 1'b0);
    chk("beq.nt.bp_pc", bp_PC, 32'h24);
    take_en = 1'b1;
    take_pc = 32'h24;
    tick();
    chk_out("nonbr", NOP, 32'h24, 1'b0, 1'b0);
    chk("nonbr.bp_pc", bp_PC, 32'h28);

    // predicted-taken c.beqz x8,+8
    take_pc = 32'h60;
    do_flush("fl60", 32'h60);
    tick();
    chk_out("beqz.t", 32'h0004_0463, 32'h60, 1'b1, 1'b1);
    chk("beqz.addr", {2'b0, ICACHE_addr}, 32'h1A);
    chk("beqz.bp_pc", bp_PC, 32'h68);
    tick();
    chk_out("beqz.tgt", NOP, 32'h68, 1'b0, 1'b0);
    take_en = 1'b0;

    // expansion table
    do_flush("flC0", 32'hC0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_out($sformatf("exp%0d", i), exp_tab[i], 32'hC0 + 32'(2 * i), 1'b1, 1'b0);
    end
    chk("exp.addr", {2'b0, ICACHE_addr}, 32'h34);

    // stalls freeze the stage; flush waits for memory_stall to drop
    do_flush("fl0", 32'h0);
    tick();
    chk_out("st.w0", 32'h00A0_0093, 32'h0, 1'b0, 1'b0);
    memory_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("mstall", 32'h00A0_0093, 32'h0, 1'b0, 1'b0);
      chk("mstall.addr", {2'b0, ICACHE_addr}, 32'h1);
      chk("mstall.bp_pc", bp_PC, 32'h4);
    end
    memory_stall = 1'b0;
    hazard_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("hstall", 32'h00A0_0093, 32'h0, 1'b0, 1'b0);
      chk("hstall.addr", {2'b0, ICACHE_addr}, 32'h1);
    end
    hazard_stall = 1'b0;
    tick();
    chk_out("st.w1", 32'h0010_8113, 32'h4, 1'b0, 1'b0);
    memory_stall = 1'b1;
    flush        = 1'b1;
    flush_PC     = 32'h40;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_out("mstall.fl", 32'h0010_8113, 32'h4, 1'b0, 1'b0);
      chk("mstall.fl.addr", {2'b0, ICACHE_addr}, 32'h2);
    end
    memory_stall = 1'b0;
    tick();
    flush = 1'b0;
    chk_out("late.fl", NOP, 32'h0, 1'b0, 1'b0);
    chk("late.fl.addr", {2'b0, ICACHE_addr}, 32'h10);
    tick();
    chk_out("late.A", 32'h0010_0513, 32'h40, 1'b1, 1'b0);

    // flush outranks hazard_stall
    hazard_stall = 1'b1;
    flush        = 1'b1;
    flush_PC     = 32'h80;
    tick();
    flush = 1'b0;
    chk_out("hz.fl", NOP, 32'h0, 1'b0, 1'b0);
    chk("hz.fl.addr", {2'b0, ICACHE_addr}, 32'h20);
    tick();
    chk_out("hz.hold", NOP, 32'h0, 1'b0, 1'b0);
    hazard_stall = 1'b0;
    tick();
    chk_out("hz.A", 32'h0010_0513, 32'h80, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
